// File: rtl/ram8k16_pkg.sv
// Shared types and helpers for the 8+8-bit RAM initiator.
// Holds the FSM state encoding, the byte-lane constants and the byte-merge function.
package ram8k16_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned LANES  = DATA_W / 8;

   typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

   // Enabled lanes come from new_data; the rest keep old_data.
   function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_data,
                                                  input logic [DATA_W-1:0] new_data,
                                                  input logic [LANES-1:0]  be);
      logic [DATA_W-1:0] merged;
      merged = old_data;
      for (int i = 0; i < LANES; i++) begin
         if (be[i]) merged[i*8 +: 8] = new_data[i*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram8k16_initiator_if.sv
// Host-side request/response channel of the RAM initiator.
// The host drives the master modport; the initiator uses the slave modport.
interface ram8k16_initiator_if
   import ram8k16_pkg::*;
#(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = DATA_W
);
   logic             req_valid;
   logic             req_ready;
   logic             req_wr;
   logic [AW-1:0]    req_addr;
   logic [DW-1:0]    req_wdata;
   logic [LANES-1:0] req_be;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [DW-1:0]    rsp_rdata;
   logic             rsp_err;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/ram8k16_initiator.sv
// Single-outstanding host initiator for the 2-bank synchronous RAM.
// Runs read, full write and read-modify-write byte-enable cycles; range-checks addresses.
module ram8k16_initiator
   import ram8k16_pkg::*;
#(
   parameter int unsigned AW    = 10,
   parameter int unsigned DEPTH = 10,
   parameter int unsigned DW    = DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   ram8k16_initiator_if.slave bus,
   output logic              err_flag,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_wr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata
);

   state_t           state;
   logic             held_wr;
   logic [LANES-1:0] held_be;
   logic             in_range;
   logic             accept;

   assign in_range      = 32'(bus.req_addr) < DEPTH;
   assign bus.req_ready = (state == IDLE) & ~bus.rsp_valid & ~reset;
   assign accept        = bus.req_valid & bus.req_ready;
   assign mem_wr        = (state == WR);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         held_wr       <= 1'b0;
         held_be       <= '0;
         err_flag      <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
         end

         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (!in_range) begin
                     // Out-of-range: no RAM cycle; reads get an immediate error response.
                     err_flag <= 1'b1;
                     if (!bus.req_wr) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= '0;
                     end
                  end else begin
                     mem_addr  <= bus.req_addr;
                     mem_wdata <= bus.req_wdata;
                     held_wr   <= bus.req_wr;
                     held_be   <= bus.req_be;
                     if (!bus.req_wr)                state <= RD;
                     else if (bus.req_be == '1)      state <= WR;
                     else if (bus.req_be != '0)      state <= RD;
                  end
               end
            end
            RD:  state <= CAP;
            CAP: begin
               if (held_wr) begin
                  mem_wdata <= be_merge(mem_rdata, mem_wdata, held_be);
                  state     <= WR;
               end else begin
                  bus.rsp_rdata <= mem_rdata;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_err   <= 1'b0;
                  state         <= IDLE;
               end
            end
            WR:      state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram8k16_initiator.sv
// Self-checking bench for ram8k16_initiator with a behavioural synchronous RAM.
// Table vectors, hand sequences for hold/reset corners, then random traffic against a word-level model.
module tb_ram8k16_initiator;

   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 10;
   localparam int unsigned DW    = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          err_flag;
   logic [AW-1:0] mem_addr;
   logic          mem_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DW-1:0] mem_m [DEPTH];
   logic          err_m;
   logic [DW-1:0] ram   [2**AW];

   logic [DW-1:0] rd;
   logic          er;
   int            n;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [1:0]    be;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;
   vec_t vecs [12];

   ram8k16_initiator_if #(.AW(AW), .DW(DW)) bus ();

   ram8k16_initiator #(.AW(AW), .DEPTH(DEPTH), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .err_flag  (err_flag),
      .mem_addr  (mem_addr),
      .mem_wr    (mem_wr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // RAM: reset clears every word and dominates a coincident write.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2**AW; i++) ram[i] <= '0;
         mem_rdata <= '0;
      end else if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
      end else begin
         mem_rdata <= ram[mem_addr];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
      err_m = 1'b0;
   endtask

   // One complete host transaction, entered and left just after a falling edge.
   task automatic xact(input string tag, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [1:0] be,
                       output logic [DW-1:0] rdata, output logic err);
      logic          in_rng;
      logic [DW-1:0] mask;
      logic [DW-1:0] exp_val;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      int            ai, c, k, wr_seen, wr_pos, exp_done, exp_wrs;
      ai      = int'(addr);
      in_rng  = ai < DEPTH;
      mask    = {{8{be[1]}}, {8{be[0]}}};
      exp_val = '0;
      if (in_rng) exp_val = wr ? ((mem_m[ai] & ~mask) | (wd & mask)) : mem_m[ai];
      rdata   = '0;
      err     = 1'b0;
      wr_seen = 0;
      wr_pos  = 0;
      wr_addr = '0;
      wr_data = '0;

      bus.req_valid = 1'b1;
      bus.req_wr    = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wd;
      bus.req_be    = be;
      k = 0;
      while (!bus.req_ready && k < 20) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = AW'($urandom);
      bus.req_wdata = DW'($urandom);
      bus.req_be    = 2'($urandom);
      c = 1;

      if (!wr) begin
         while (!bus.rsp_valid && c < 20) begin
            if (mem_wr) wr_seen++;
            @(negedge clk);
            c++;
         end
         check({tag, "_rd_latency"}, c, in_rng ? 32'd3 : 32'd1);
         check({tag, "_rd_no_write"}, wr_seen, 32'd0);
         rdata = bus.rsp_rdata;
         err   = bus.rsp_err;
         check({tag, "_rdata"}, 32'(rdata), 32'(exp_val));
         check({tag, "_rsp_err"}, 32'(err), 32'(!in_rng));
         err_m = err_m | !in_rng;
         check({tag, "_err_flag"}, 32'(err_flag), 32'(err_m));
         bus.rsp_ready = 1'b1;
         @(negedge clk);
         bus.rsp_ready = 1'b0;
         check({tag, "_rsp_clear"}, 32'(bus.rsp_valid), 32'd0);
      end else begin
         while (!bus.req_ready && c < 20) begin
            if (mem_wr) begin
               wr_seen++;
               wr_pos  = c;
               wr_addr = mem_addr;
               wr_data = mem_wdata;
            end
            @(negedge clk);
            c++;
         end
         exp_done = !in_rng ? 1 : (be == 2'b11) ? 2 : (be == 2'b00) ? 1 : 4;
         exp_wrs  = (in_rng && be != 2'b00) ? 1 : 0;
         check({tag, "_wr_done"}, c, exp_done);
         check({tag, "_wr_count"}, wr_seen, exp_wrs);
         if (exp_wrs == 1) begin
            check({tag, "_wr_pos"}, wr_pos, (be == 2'b11) ? 32'd1 : 32'd3);
            check({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr));
            check({tag, "_wr_data"}, 32'(wr_data), 32'(exp_val));
            mem_m[ai] = exp_val;
         end
         check({tag, "_wr_no_rsp"}, 32'(bus.rsp_valid), 32'd0);
         err_m = err_m | !in_rng;
         check({tag, "_err_flag"}, 32'(err_flag), 32'(err_m));
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_wr    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_be    = '0;
      bus.rsp_ready = 1'b0;

      vecs[0]  = '{1'b1, 10'd3,  16'hA55A, 2'b11, 16'h0000, 1'b0};
      vecs[1]  = '{1'b0, 10'd3,  16'h0000, 2'b11, 16'hA55A, 1'b0};
      vecs[2]  = '{1'b1, 10'd5,  16'h1234, 2'b11, 16'h0000, 1'b0};
      vecs[3]  = '{1'b1, 10'd5,  16'hFFEE, 2'b01, 16'h0000, 1'b0};
      vecs[4]  = '{1'b0, 10'd5,  16'h0000, 2'b00, 16'h12EE, 1'b0};
      vecs[5]  = '{1'b1, 10'd5,  16'hFFEE, 2'b10, 16'h0000, 1'b0};
      vecs[6]  = '{1'b0, 10'd5,  16'h0000, 2'b11, 16'hFFEE, 1'b0};
      vecs[7]  = '{1'b0, 10'd12, 16'h0000, 2'b11, 16'h0000, 1'b1};
      vecs[8]  = '{1'b1, 10'd12, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
      vecs[9]  = '{1'b1, 10'd0,  16'h7777, 2'b00, 16'h0000, 1'b0};
      vecs[10] = '{1'b0, 10'd0,  16'h0000, 2'b11, 16'h0000, 1'b0};
      vecs[11] = '{1'b0, 10'd9,  16'h0000, 2'b01, 16'h0000, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
      check("rst_err_flag", 32'(err_flag), 32'd0);
      check("rst_mem_wr", 32'(mem_wr), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_ready_rises", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         xact($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be,
              rd, er);
         if (!vecs[i].wr) begin
            check($sformatf("vec%0d_tbl_rdata", i), 32'(rd), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_tbl_err", i), 32'(er), 32'(vecs[i].exp_err));
         end
      end
      check("tbl_err_sticky", 32'(err_flag), 32'd1);

      // Response held while rsp_ready is low; next request waits for the clearing edge.
      xact("hold_pre", 1'b1, 10'd0, 16'h5A01, 2'b11, rd, er);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 10'd0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("hold_rsp", 32'(bus.rsp_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("hold_rdata", 32'(bus.rsp_rdata), 32'h5A01);
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 10'd0;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("hold_clear", 32'(bus.rsp_valid), 32'd0);
      check("hold_not_early", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("hold_next_taken", 32'(bus.req_ready), 32'd0);
      n = 0;
      while (!bus.rsp_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("hold_next_rdata", 32'(bus.rsp_rdata), 32'h5A01);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;

      // Reset during the write phase of a read-modify-write.
      xact("rstwr_pre", 1'b1, 10'd4, 16'hBEEF, 2'b11, rd, er);
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b1;
      bus.req_addr  = 10'd4;
      bus.req_wdata = 16'h1111;
      bus.req_be    = 2'b01;
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 0;
      while (!mem_wr && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("rstwr_in_wr", 32'(mem_wr), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rstwr_mem_wr", 32'(mem_wr), 32'd0);
      check("rstwr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      reset = 1'b0;
      model_reset();
      #1;
      check("rstwr_idle", 32'(bus.req_ready), 32'd1);
      xact("rstwr_read", 1'b0, 10'd4, 16'h0000, 2'b11, rd, er);
      check("rstwr_word_zero", 32'(rd), 32'd0);

      // Pending error response discarded by reset.
      bus.req_valid = 1'b1;
      bus.req_wr    = 1'b0;
      bus.req_addr  = 10'd11;
      @(negedge clk);
      bus.req_valid = 1'b0;
      check("drop_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("drop_rsp_err", 32'(bus.rsp_err), 32'd1);
      check("drop_err_flag", 32'(err_flag), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check("drop_cleared", 32'(bus.rsp_valid), 32'd0);
      check("drop_flag_cleared", 32'(err_flag), 32'd0);
      check("drop_ready", 32'(bus.req_ready), 32'd1);

      // Random traffic against the word-level model.
      for (int i = 0; i < 250; i++) begin
         xact($sformatf("rnd%0d", i), 1'($urandom), AW'($urandom_range(0, DEPTH + 2)),
              DW'($urandom), 2'($urandom), rd, er);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
